hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline hazard/stall controller; drives write-enable and flush of IF/ID, PC and ID/EX in the 5-stage core.
//   Detects load-use hazards, applies taken-branch/jump flush, freezes pipeline while data memory is not ready.
//   Keeps a memory-wait watchdog and saturating stall/flush performance counters.
// PARAMETERS
//   TIMEOUT  16  consecutive frozen cycles in MEM_WAIT before timeout_o sets (>=2)
//   CNT_W    32  width of perf counters stall_cnt_o / flush_cnt_o
// PORTS
//   clk_i            in   1      clock; all state updates on posedge
//   rst_i            in   1      synchronous, active-high reset
//   IDEX_MemRead_i   in   1      instruction in EX is a load
//   IDEX_RegRt_i     in   5      load destination register
//   IFID_RegRs_i     in   5      ID-stage source rs
//   IFID_RegRt_i     in   5      ID-stage source rt
//   IFID_UseRs_i     in   1      ID instruction reads rs
//   IFID_UseRt_i     in   1      ID instruction reads rt
//   branch_taken_i   in   1      branch resolved taken in ID
//   jump_i           in   1      jump in ID
//   mem_req_i        in   1      MEM stage has active data-memory access
//   mem_ready_i      in   1      data memory completes access this cycle
//   PCWrite_o        out  1      PC update enable
//   IFIDWrite_o      out  1      IF/ID update enable
//   IFFlush_o        out  1      IF/ID clear to NOP
//   IDEXBubble_o     out  1      insert NOP into ID/EX
//   PipeFreeze_o     out  1      hold ID/EX, EX/MEM, MEM/WB
//   timeout_o        out  1      sticky memory-wait watchdog flag
//   stall_cnt_o      out  CNT_W  cycles with PCWrite_o==0
//   flush_cnt_o      out  CNT_W  cycles with IFFlush_o==1
// BEHAVIOUR
//   - Control outputs combinational from state+inputs (same-cycle effect); counters/FSM registered.
//   - freeze = mem_req_i & ~mem_ready_i. loaduse = IDEX_MemRead_i & IDEX_RegRt_i!=0 &
//     ((UseRs & Rs==IDEX_RegRt) | (UseRt & Rt==IDEX_RegRt)). redirect = branch_taken_i | jump_i.
//   - Priority freeze > loaduse > redirect:
//       freeze:  PCWrite=0 IFIDWrite=0 IFFlush=0 IDEXBubble=0 PipeFreeze=1 (branch held, no flush)
//       loaduse: PCWrite=0 IFIDWrite=0 IFFlush=0 IDEXBubble=1 PipeFreeze=0
//       redirect:PCWrite=1 IFIDWrite=1 IFFlush=1 IDEXBubble=0 PipeFreeze=0
//       none:    PCWrite=1 IFIDWrite=1, others 0
//   - FSM RUN/MEM_WAIT: RUN->MEM_WAIT when freeze; MEM_WAIT->RUN when ~freeze (cycle with ready is unfrozen).
//   - wait_cnt: 1 on RUN->MEM_WAIT, +1 per frozen MEM_WAIT cycle, 0 in RUN; timeout_o sets the cycle after
//     the TIMEOUT-th consecutive frozen cycle; sticky until reset; pipeline keeps waiting.
//   - stall_cnt_o +1 per cycle PCWrite_o==0; flush_cnt_o +1 per cycle IFFlush_o==1; both saturate at all-ones.
//   - Reset (rst_i high, any state): PCWrite=0 IFIDWrite=0 IFFlush=1 IDEXBubble=1 PipeFreeze=0;
//     next cycle state=RUN, wait_cnt=0, timeout_o=0, counters=0; counters not incremented during reset.
//   - Reset mid MEM_WAIT abandons wait; no residual freeze unless freeze still asserted after reset.
// STRUCTURE
//   - hazard_defs.vh: state encodings ST_RUN/ST_MEM_WAIT, REG_W=5, REG_ZERO=5'd0.
//   - Sub-module sat_counter (params W; ports clk_i, rst_i, inc_i, cnt_o), instanced for stall and flush.
//   - Top holds FSM, wait counter, watchdog, combinational hazard/priority logic.
// TESTING
//   - Load-use: MemRead=1 RegRt=2, Rs=2 UseRs=1 -> PCWrite=0 IFIDWrite=0 IDEXBubble=1; next cycle
//     MemRead=0 -> PCWrite=1 IFIDWrite=1; stall_cnt_o=1.
//   - Zero reg: MemRead=1 RegRt=0, Rs=0 UseRs=1 -> no stall, PCWrite=1, stall_cnt_o=0.
//   - Branch: branch_taken_i=1, no hazard -> IFFlush=1 PCWrite=1 IFIDWrite=1; flush_cnt_o=1.
//   - Mem wait: req=1 ready=0 for 5 cycles with branch_taken=1 -> PipeFreeze=1 IFFlush=0 all 5;
//     ready=1 -> IFFlush=1 that cycle; stall_cnt_o=5, state RUN next cycle.
//   - Watchdog TIMEOUT=8: 7 frozen cycles -> timeout_o=0; 8 frozen -> timeout_o=1 on cycle 9, stays 1
//     after ready; rst_i -> 0.
//   - Reset mid MEM_WAIT (cycle 3 of wait, req deasserted) -> next cycle RUN, counters 0, PCWrite=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-field
// widths, the memory-wait FSM encoding and a source/destination match helper.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  // True when an ID-stage source is actually read and names the load destination.
  function automatic logic src_match(input logic use_src,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return use_src & (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Sticks at all-ones so a long run never wraps back to a small value.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count qualifying cycles, holding at the maximum value once reached.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + ONE;
    end else begin
      cnt_o <= cnt_o;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage core. Control outputs are
// combinational (same-cycle effect); the memory-wait FSM, watchdog and
// performance counters are registered.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [REG_W-1:0] IDEX_RegRt_i,
  input  logic [REG_W-1:0] IFID_RegRs_i,
  input  logic [REG_W-1:0] IFID_RegRt_i,
  input  logic             IFID_UseRs_i,
  input  logic             IFID_UseRt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFFlush_o,
  output logic             IDEXBubble_o,
  output logic             PipeFreeze_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Wide enough to hold TIMEOUT itself; the wait counter saturates there.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              freeze;
  logic              loaduse;
  logic              redirect;

  assign freeze   = mem_req_i & ~mem_ready_i;
  assign loaduse  = IDEX_MemRead_i & (IDEX_RegRt_i != REG_ZERO) &
                    (src_match(IFID_UseRs_i, IFID_RegRs_i, IDEX_RegRt_i) |
                     src_match(IFID_UseRt_i, IFID_RegRt_i, IDEX_RegRt_i));
  assign redirect = branch_taken_i | jump_i;

  // FSM state register; reset abandons any pending memory wait.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and prioritised control outputs: freeze > load-use > redirect.
  always_comb begin
    next_state   = state;
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IFFlush_o    = 1'b0;
    IDEXBubble_o = 1'b0;
    PipeFreeze_o = 1'b0;

    case (state)
      ST_RUN:      next_state = freeze ? ST_MEM_WAIT : ST_RUN;
      ST_MEM_WAIT: next_state = freeze ? ST_MEM_WAIT : ST_RUN;
      default:     next_state = ST_RUN;
    endcase

    if (rst_i) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IFFlush_o    = 1'b1;
      IDEXBubble_o = 1'b1;
      PipeFreeze_o = 1'b0;
    end else if (freeze) begin
      // A resolved branch is held, not flushed, until memory releases.
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      PipeFreeze_o = 1'b1;
    end else if (loaduse) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IDEXBubble_o = 1'b1;
    end else if (redirect) begin
      IFFlush_o    = 1'b1;
    end else begin
      PCWrite_o    = 1'b1;
      IFIDWrite_o  = 1'b1;
    end
  end

  // Frozen-cycle count including the current cycle, saturating at the limit.
  always_comb begin
    wait_inc = WAIT_ONE;
    if (state == ST_RUN) begin
      wait_inc = WAIT_ONE;
    end else if (wait_cnt >= WAIT_LIM) begin
      wait_inc = WAIT_LIM;
    end else begin
      wait_inc = wait_cnt + WAIT_ONE;
    end
  end

  // Watchdog: count consecutive frozen cycles and latch timeout until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else if (freeze) begin
      wait_cnt <= wait_inc;
      if (wait_inc >= WAIT_LIM) begin
        timeout_o <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~PCWrite_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (IFFlush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: TIMEOUT=8 and narrow 4-bit counters so
// watchdog and counter saturation are reachable in a short run.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          IDEX_MemRead_i;
  logic [4:0]    IDEX_RegRt_i;
  logic [4:0]    IFID_RegRs_i;
  logic [4:0]    IFID_RegRt_i;
  logic          IFID_UseRs_i;
  logic          IFID_UseRt_i;
  logic          branch_taken_i;
  logic          jump_i;
  logic          mem_req_i;
  logic          mem_ready_i;
  logic          PCWrite_o;
  logic          IFIDWrite_o;
  logic          IFFlush_o;
  logic          IDEXBubble_o;
  logic          PipeFreeze_o;
  logic          timeout_o;
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.TIMEOUT(8), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RegRt_i   (IDEX_RegRt_i),
    .IFID_RegRs_i   (IFID_RegRs_i),
    .IFID_RegRt_i   (IFID_RegRt_i),
    .IFID_UseRs_i   (IFID_UseRs_i),
    .IFID_UseRt_i   (IFID_UseRt_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .PCWrite_o      (PCWrite_o),
    .IFIDWrite_o    (IFIDWrite_o),
    .IFFlush_o      (IFFlush_o),
    .IDEXBubble_o   (IDEXBubble_o),
    .PipeFreeze_o   (PipeFreeze_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the five control outputs as one packed vector {PC,IFID,Flush,Bubble,Freeze}.
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, PCWrite_o, IFIDWrite_o, IFFlush_o, IDEXBubble_o, PipeFreeze_o},
          {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IDEX_MemRead_i = 1'b0; IDEX_RegRt_i = 5'd0;
    IFID_RegRs_i = 5'd0; IFID_RegRt_i = 5'd0;
    IFID_UseRs_i = 1'b0; IFID_UseRt_i = 1'b0;
    branch_taken_i = 1'b0; jump_i = 1'b0;
    mem_req_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    #1;
    check_ctl("reset_ctl", 5'b00110);
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check("reset_timeout", {31'd0, timeout_o}, 32'd0);
    check("reset_stall", {28'd0, stall_cnt_o}, 32'd0);
    check("reset_flush", {28'd0, flush_cnt_o}, 32'd0);
    check_ctl("idle_ctl", 5'b11000);

    // Load-use on rs.
    IDEX_MemRead_i = 1'b1; IDEX_RegRt_i = 5'd2; IFID_RegRs_i = 5'd2; IFID_UseRs_i = 1'b1;
    #1;
    check_ctl("loaduse_rs_ctl", 5'b00010);
    tick();
    IDEX_MemRead_i = 1'b0;
    #1;
    check_ctl("loaduse_release_ctl", 5'b11000);
    check("loaduse_stall_cnt", {28'd0, stall_cnt_o}, 32'd1);

    // rt matches but rt not used: no hazard; then used: hazard.
    IDEX_MemRead_i = 1'b1; IDEX_RegRt_i = 5'd7; IFID_RegRs_i = 5'd3;
    IFID_RegRt_i = 5'd7; IFID_UseRt_i = 1'b0;
    #1;
    check_ctl("rt_unused_ctl", 5'b11000);
    IFID_UseRt_i = 1'b1;
    #1;
    check_ctl("loaduse_rt_ctl", 5'b00010);
    tick();
    check("loaduse_rt_stall_cnt", {28'd0, stall_cnt_o}, 32'd2);

    // Load into r0 never stalls.
    idle();
    IDEX_MemRead_i = 1'b1; IDEX_RegRt_i = 5'd0; IFID_RegRs_i = 5'd0; IFID_UseRs_i = 1'b1;
    #1;
    check_ctl("zero_reg_ctl", 5'b11000);
    tick();
    check("zero_reg_stall_cnt", {28'd0, stall_cnt_o}, 32'd2);

    // Taken branch, then jump.
    idle();
    branch_taken_i = 1'b1;
    #1;
    check_ctl("branch_ctl", 5'b11100);
    tick();
    check("branch_flush_cnt", {28'd0, flush_cnt_o}, 32'd1);
    branch_taken_i = 1'b0; jump_i = 1'b1;
    #1;
    check_ctl("jump_ctl", 5'b11100);
    tick();
    check("jump_flush_cnt", {28'd0, flush_cnt_o}, 32'd2);

    // Load-use outranks a redirect.
    IDEX_MemRead_i = 1'b1; IDEX_RegRt_i = 5'd4; IFID_RegRs_i = 5'd4; IFID_UseRs_i = 1'b1;
    #1;
    check_ctl("loaduse_over_jump_ctl", 5'b00010);
    tick();
    check("loaduse_over_jump_stall", {28'd0, stall_cnt_o}, 32'd3);
    check("loaduse_over_jump_flush", {28'd0, flush_cnt_o}, 32'd2);

    // Memory wait for 5 cycles with a branch held, then release.
    idle();
    branch_taken_i = 1'b1; mem_req_i = 1'b1; mem_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_ctl($sformatf("memwait_ctl_%0d", i), 5'b00001);
      tick();
    end
    check("memwait_stall_cnt", {28'd0, stall_cnt_o}, 32'd8);
    mem_ready_i = 1'b1;
    #1;
    check_ctl("memready_ctl", 5'b11100);
    tick();
    check("memready_state", {31'd0, dut.state}, {31'd0, ST_RUN});
    check("memready_flush_cnt", {28'd0, flush_cnt_o}, 32'd3);
    check("memready_timeout", {31'd0, timeout_o}, 32'd0);

    // Watchdog: 7 frozen cycles no timeout, 8th sets it; stall counter saturates.
    idle();
    mem_req_i = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("wd_7_timeout", {31'd0, timeout_o}, 32'd0);
    tick();
    check("wd_8_timeout", {31'd0, timeout_o}, 32'd1);
    check("stall_saturate", {28'd0, stall_cnt_o}, 32'd15);
    mem_ready_i = 1'b1;
    tick();
    check("wd_sticky", {31'd0, timeout_o}, 32'd1);
    check("wd_sticky_state", {31'd0, dut.state}, {31'd0, ST_RUN});

    // Reset in the third cycle of a wait with the request dropped.
    idle();
    mem_req_i = 1'b1;
    tick(); tick();
    rst_i = 1'b1; mem_req_i = 1'b0;
    #1;
    check_ctl("midwait_reset_ctl", 5'b00110);
    tick();
    rst_i = 1'b0;
    #1;
    check_ctl("after_reset_ctl", 5'b11000);
    check("after_reset_state", {31'd0, dut.state}, {31'd0, ST_RUN});
    check("after_reset_timeout", {31'd0, timeout_o}, 32'd0);
    check("after_reset_stall", {28'd0, stall_cnt_o}, 32'd0);
    check("after_reset_flush", {28'd0, flush_cnt_o}, 32'd0);

    // Flush counter saturation.
    jump_i = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check("flush_saturate", {28'd0, flush_cnt_o}, 32'd15);
    check("flush_run_stall", {28'd0, stall_cnt_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
